// File: rtl/cray_vec_pkg.sv
// Shared vector-unit definitions: functional-unit source codes, streamer state
// encoding and the write-slot timing constants used by the memory streamer.
package cray_vec_pkg;

  localparam logic [2:0] FU_ADD   = 3'b000;
  localparam logic [2:0] FU_LOG   = 3'b001;
  localparam logic [2:0] FU_SHIFT = 3'b010;
  localparam logic [2:0] FU_MUL   = 3'b011;
  localparam logic [2:0] FU_RECIP = 3'b100;
  localparam logic [2:0] FU_MEM   = 3'b111;

  // A write-started register expects element k at start + fu_time + WSLOT_OFS + k.
  localparam int WSLOT_OFS    = 5;
  localparam int FU_TIME_BIAS = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_REQ   = 3'd1,
    LD_DRAIN = 3'd2,
    ST_WAIT  = 3'd3,
    ST_REQ   = 3'd4
  } vms_state_e;

endpackage

// File: rtl/vec_addr_gen.sv
// Strided address generator: loads base/stride on start, steps by stride per
// issued request, wrapping modulo 2^ADDR_W.
module vec_addr_gen #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (adv) begin
      addr     <= addr + stride_q;
    end
  end

endmodule

// File: rtl/vec_mem_stream.sv
// Vector load/store streamer between central memory and one vector register:
// strided reads feed the register's MEM write source, stores drain it to memory.
module vec_mem_stream
  import cray_vec_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 24,
  parameter int LOGDEPTH = 6,
  parameter int MEM_LAT  = 11,
  parameter int RD_LAT   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_store,
  input  logic [ADDR_W-1:0]   i_base,
  input  logic [ADDR_W-1:0]   i_stride,
  input  logic [LOGDEPTH:0]   i_vector_length,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [WIDTH-1:0]    o_mem_wdata,
  input  logic [WIDTH-1:0]    i_mem_rdata,
  output logic                o_vwrite_start,
  output logic                o_vread_start,
  output logic [2:0]          o_fu,
  output logic [3:0]          o_fu_time,
  output logic [WIDTH-1:0]    o_vdata,
  input  logic [WIDTH-1:0]    i_vdata
);

  localparam int LAT_W   = 8;
  localparam int FU_TIME = MEM_LAT - FU_TIME_BIAS;
  // Drain ends on the last element's write slot: slot = 1 + FU_TIME + WSLOT_OFS + (VL-1).
  localparam int DRAIN_CNT = FU_TIME + WSLOT_OFS - 1;
  localparam logic [LOGDEPTH:0] MAX_VL = (LOGDEPTH+1)'(1 << LOGDEPTH);

  vms_state_e        state, state_nxt;
  logic [LOGDEPTH:0] vl_q, elem, vl_clamp;
  logic [LAT_W-1:0]  lat;
  logic              zero_done, start_ok, last_elem, fin, vl_nz;
  logic [WIDTH-1:0]  vdata_q;

  assign vl_clamp  = (i_vector_length > MAX_VL) ? MAX_VL : i_vector_length;
  assign vl_nz     = (vl_clamp != '0);
  assign start_ok  = i_start & ~o_busy;
  assign last_elem = (elem == vl_q - 1'b1);

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    case (state)
      IDLE:     if (start_ok && vl_nz) state_nxt = i_store ? ST_WAIT : LD_REQ;
      LD_REQ:   if (last_elem) state_nxt = LD_DRAIN;
      LD_DRAIN: if (lat == '0) begin
                  state_nxt = IDLE;
                  fin       = 1'b1;
                end
      ST_WAIT:  if (lat == '0) state_nxt = ST_REQ;
      ST_REQ:   if (last_elem) begin
                  state_nxt = IDLE;
                  fin       = 1'b1;
                end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vl_q           <= '0;
      elem           <= '0;
      lat            <= '0;
      zero_done      <= 1'b0;
      o_vwrite_start <= 1'b0;
      o_vread_start  <= 1'b0;
    end else begin
      // VL=0 never leaves IDLE; this flag alone carries busy/done for one cycle.
      zero_done      <= start_ok & ~vl_nz;
      o_vwrite_start <= start_ok & ~i_store & vl_nz;
      o_vread_start  <= start_ok &  i_store & vl_nz;
      if (start_ok) begin
        vl_q <= vl_clamp;
        elem <= '0;
        lat  <= LAT_W'(RD_LAT);
      end else begin
        case (state)
          LD_REQ, ST_REQ: begin
            elem <= elem + 1'b1;
            if (state == LD_REQ && last_elem) lat <= LAT_W'(DRAIN_CNT);
          end
          LD_DRAIN, ST_WAIT: if (lat != '0) lat <= lat - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vdata_q <= '0;
      o_vdata <= '0;
    end else begin
      vdata_q <= i_vdata;
      o_vdata <= i_mem_rdata;
    end
  end

  assign o_busy      = (state != IDLE) | zero_done;
  assign o_done      = fin | zero_done;
  assign o_mem_req   = (state == LD_REQ) | (state == ST_REQ);
  assign o_mem_we    = (state == ST_REQ);
  assign o_mem_wdata = vdata_q;
  assign o_fu        = FU_MEM;
  assign o_fu_time   = 4'(FU_TIME);

  vec_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk    (clk),
    .rst    (rst),
    .load   (start_ok),
    .adv    (o_mem_req),
    .base   (i_base),
    .stride (i_stride),
    .addr   (o_mem_addr)
  );

endmodule

// File: tb/tb_vec_mem_stream.sv
// Directed bench for vec_mem_stream: logs per-cycle activity relative to the
// start cycle and compares it against hand-computed cycle/address/data tables.
module tb_vec_mem_stream;

  localparam int WIDTH = 64, ADDR_W = 24, LOGDEPTH = 6, MEM_LAT = 11, RD_LAT = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                i_start = 1'b0;
  logic                i_store = 1'b0;
  logic [ADDR_W-1:0]   i_base = '0;
  logic [ADDR_W-1:0]   i_stride = '0;
  logic [LOGDEPTH:0]   i_vector_length = '0;
  logic                o_busy, o_done, o_mem_req, o_mem_we;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [WIDTH-1:0]    o_mem_wdata, i_mem_rdata, o_vdata;
  logic [WIDTH-1:0]    i_vdata = '0;
  logic                o_vwrite_start, o_vread_start;
  logic [2:0]          o_fu;
  logic [3:0]          o_fu_time;

  vec_mem_stream #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LOGDEPTH(LOGDEPTH),
                   .MEM_LAT(MEM_LAT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_store(i_store),
    .i_base(i_base), .i_stride(i_stride), .i_vector_length(i_vector_length),
    .o_busy(o_busy), .o_done(o_done), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_vwrite_start(o_vwrite_start), .o_vread_start(o_vread_start),
    .o_fu(o_fu), .o_fu_time(o_fu_time), .o_vdata(o_vdata), .i_vdata(i_vdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, c0 = 0, rel;
  bit log_en = 1'b0;

  int rq_cyc[$], dn_cyc[$], vw_cyc[$], vr_cyc[$];
  logic [ADDR_W-1:0] rq_addr[$];
  logic              rq_we[$];
  logic [WIDTH-1:0]  rq_wd[$];
  logic [WIDTH-1:0]  vd_log[0:127];
  logic [WIDTH-1:0]  vd_tab[0:127];
  bit                busy_log[0:127];
  bit                zero_log[0:127];

  // Memory model: fixed-latency read pipe, data tagged with its address.
  logic [WIDTH-1:0]  rpipe[0:31];
  logic [WIDTH-1:0]  rq_d = '0;

  function automatic logic [WIDTH-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 64'hC0DE_0000_0000_0000 | {40'b0, a};
  endfunction

  initial for (int i = 0; i < 32; i++) rpipe[i] = '0;
  assign i_mem_rdata = rpipe[MEM_LAT-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 31; i > 0; i--) rpipe[i] <= rpipe[i-1];
    rpipe[0] <= rq_d;
  end

  always @(negedge clk) begin
    rq_d <= (o_mem_req && !o_mem_we) ? mem_word(o_mem_addr) : '0;
    if (log_en) begin
      rel = cyc - c0;
      if (rel >= 0 && rel < 128) begin
        if (o_mem_req) begin
          rq_cyc.push_back(rel); rq_addr.push_back(o_mem_addr);
          rq_we.push_back(o_mem_we); rq_wd.push_back(o_mem_wdata);
        end
        if (o_done)         dn_cyc.push_back(rel);
        if (o_vwrite_start) vw_cyc.push_back(rel);
        if (o_vread_start)  vr_cyc.push_back(rel);
        vd_log[rel]   = o_vdata;
        busy_log[rel] = o_busy;
        zero_log[rel] = !(o_busy | o_done | o_mem_req | o_mem_we | o_vwrite_start |
                          o_vread_start | (|o_mem_addr) | (|o_mem_wdata) | (|o_vdata));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic clr;
    rq_cyc.delete(); rq_addr.delete(); rq_we.delete(); rq_wd.delete();
    dn_cyc.delete(); vw_cyc.delete(); vr_cyc.delete();
    for (int i = 0; i < 128; i++) begin
      vd_log[i] = '0; busy_log[i] = 1'b0; zero_log[i] = 1'b0;
    end
  endtask

  // Starts an op in cycle 0 and runs ncyc further cycles; i_vdata follows vd_tab.
  task automatic run(input logic st, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                     input logic [LOGDEPTH:0] vl, input int ncyc, input int st2, input int rst_at);
    clr();
    step();
    i_store = st; i_base = b; i_stride = s; i_vector_length = vl;
    i_start = 1'b1; c0 = cyc; log_en = 1'b1; i_vdata = vd_tab[0];
    for (int n = 1; n <= ncyc; n++) begin
      step();
      i_start = (n == st2);
      i_vdata = vd_tab[n];
      if (n == rst_at)     rst = 1'b0;
      if (n == rst_at + 2) rst = 1'b1;
    end
    step();
    log_en = 1'b0; i_start = 1'b0;
    for (int i = 0; i < 128; i++) vd_tab[i] = '0;
  endtask

  function automatic int qi(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) vd_tab[i] = '0;
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", o_busy, 0);          chk("rst_done", o_done, 0);
    chk("rst_req", o_mem_req, 0);        chk("rst_we", o_mem_we, 0);
    chk("rst_addr", o_mem_addr, 0);      chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_vws", o_vwrite_start, 0);   chk("rst_vrs", o_vread_start, 0);
    chk("rst_vdata", o_vdata, 0);
    chk("rst_fu", o_fu, 3'b111);         chk("rst_fu_time", o_fu_time, 7);

    // Load VL=4, base 0x100, stride 2
    run(1'b0, 24'h000100, 24'd2, 7'd4, 20, -1, -1);
    chk("ld_nreq", rq_cyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("ld_req_cyc", qi(rq_cyc, k), 1 + k);
      chk("ld_addr", (k < rq_addr.size()) ? rq_addr[k] : 'x, 24'h100 + 2*k);
      chk("ld_we", (k < rq_we.size()) ? rq_we[k] : 1'bx, 0);
      chk("ld_vdata", vd_log[13+k], mem_word(24'h100 + 24'(2*k)));
    end
    chk("ld_nvws", vw_cyc.size(), 1);  chk("ld_vws_cyc", qi(vw_cyc, 0), 1);
    chk("ld_nvrs", vr_cyc.size(), 0);
    chk("ld_ndone", dn_cyc.size(), 1); chk("ld_done_cyc", qi(dn_cyc, 0), 16);
    chk("ld_busy0", busy_log[0], 0);   chk("ld_busy1", busy_log[1], 1);
    chk("ld_busy16", busy_log[16], 1); chk("ld_busy17", busy_log[17], 0);

    // Store VL=3, base 0x200, stride -1
    vd_tab[6] = 64'hAAAA_0000_0000_000A;
    vd_tab[7] = 64'hBBBB_0000_0000_000B;
    vd_tab[8] = 64'hCCCC_0000_0000_000C;
    run(1'b1, 24'h000200, 24'hFFFFFF, 7'd3, 14, -1, -1);
    chk("st_nreq", rq_cyc.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("st_req_cyc", qi(rq_cyc, k), 7 + k);
      chk("st_addr", (k < rq_addr.size()) ? rq_addr[k] : 'x, 24'h200 - k);
      chk("st_we", (k < rq_we.size()) ? rq_we[k] : 1'bx, 1);
    end
    chk("st_wd0", (rq_wd.size() > 0) ? rq_wd[0] : 'x, 64'hAAAA_0000_0000_000A);
    chk("st_wd1", (rq_wd.size() > 1) ? rq_wd[1] : 'x, 64'hBBBB_0000_0000_000B);
    chk("st_wd2", (rq_wd.size() > 2) ? rq_wd[2] : 'x, 64'hCCCC_0000_0000_000C);
    chk("st_nvrs", vr_cyc.size(), 1);  chk("st_vrs_cyc", qi(vr_cyc, 0), 1);
    chk("st_nvws", vw_cyc.size(), 0);
    chk("st_done_cyc", qi(dn_cyc, 0), 9); chk("st_ndone", dn_cyc.size(), 1);
    chk("st_busy9", busy_log[9], 1);   chk("st_busy10", busy_log[10], 0);

    // Address wrap
    run(1'b0, 24'hFFFFFE, 24'd1, 7'd3, 18, -1, -1);
    chk("wr_a0", (rq_addr.size() > 0) ? rq_addr[0] : 'x, 24'hFFFFFE);
    chk("wr_a1", (rq_addr.size() > 1) ? rq_addr[1] : 'x, 24'hFFFFFF);
    chk("wr_a2", (rq_addr.size() > 2) ? rq_addr[2] : 'x, 24'h000000);
    chk("wr_done_cyc", qi(dn_cyc, 0), 15);

    // VL=0
    run(1'b0, 24'h000500, 24'd1, 7'd0, 6, -1, -1);
    chk("z_nreq", rq_cyc.size(), 0);
    chk("z_nvws", vw_cyc.size(), 0);   chk("z_nvrs", vr_cyc.size(), 0);
    chk("z_ndone", dn_cyc.size(), 1);  chk("z_done_cyc", qi(dn_cyc, 0), 1);
    chk("z_busy1", busy_log[1], 1);    chk("z_busy2", busy_log[2], 0);

    // VL=100 clamps to 64
    run(1'b0, 24'h000000, 24'd1, 7'd100, 82, -1, -1);
    chk("cl_nreq", rq_cyc.size(), 64);
    chk("cl_last_addr", (rq_addr.size() > 63) ? rq_addr[63] : 'x, 24'd63);
    chk("cl_done_cyc", qi(dn_cyc, 0), 76);

    // Start while busy, mid-run and in the done cycle
    run(1'b0, 24'h000100, 24'd2, 7'd4, 22, 3, -1);
    chk("bz3_nreq", rq_cyc.size(), 4); chk("bz3_ndone", dn_cyc.size(), 1);
    run(1'b0, 24'h000100, 24'd2, 7'd4, 22, 16, -1);
    chk("bz16_nreq", rq_cyc.size(), 4); chk("bz16_busy17", busy_log[17], 0);
    chk("bz16_nvws", vw_cyc.size(), 1);

    // Reset in cycle 2 of a VL=8 load
    run(1'b0, 24'h000300, 24'd1, 7'd8, 20, -1, 2);
    chk("rm_nreq", rq_cyc.size(), 1);
    chk("rm_zero2", zero_log[2], 1);   chk("rm_zero3", zero_log[3], 1);
    chk("rm_ndone", dn_cyc.size(), 0); chk("rm_busy6", busy_log[6], 0);

    // Normal run after reset release
    run(1'b0, 24'h000040, 24'd4, 7'd2, 18, -1, -1);
    chk("ar_nreq", rq_cyc.size(), 2);
    chk("ar_a0", (rq_addr.size() > 0) ? rq_addr[0] : 'x, 24'h40);
    chk("ar_a1", (rq_addr.size() > 1) ? rq_addr[1] : 'x, 24'h44);
    chk("ar_vd13", vd_log[13], mem_word(24'h40));
    chk("ar_vd14", vd_log[14], mem_word(24'h44));
    chk("ar_done_cyc", qi(dn_cyc, 0), 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
